// File: rtl/dense_mac_ctrl.sv
// dense_mac_ctrl
//   Sequencer and multiply-accumulate engine for the dense output layer.
//   A start pulse latches one HID_DIM input vector. The block then walks the
//   row-major weight ROM, which has a 1-cycle registered read. For each of
//   the CHAR_NUM output rows it accumulates HID_DIM products and emits one
//   saturated Q7.8 logit on a valid/ready stream.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 run request (sampled only while idle)
//   x_in                  input vector, element i = x_in[i*DWIDTH +: DWIDTH]
//   busy                  high whenever not idle
//   rom_addr / rom_q      weight ROM address out, data back one cycle later
//   out_valid / out_ready logit stream handshake
//   out_data / out_idx    saturated logit and its row index
//   done                  one-cycle pulse after the last logit is taken
module dense_mac_ctrl #(
    parameter int DWIDTH   = 16,
    parameter int FRAC     = 8,
    parameter int HID_DIM  = 24,
    parameter int CHAR_NUM = 200,
    parameter int AWIDTH   = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [HID_DIM*DWIDTH-1:0]   x_in,
    output logic                        busy,
    output logic [AWIDTH-1:0]           rom_addr,
    input  logic [DWIDTH-1:0]           rom_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DWIDTH-1:0]           out_data,
    output logic [7:0]                  out_idx,
    output logic                        done
);

    localparam int ACCW = 2*DWIDTH + $clog2(HID_DIM);
    localparam int IW   = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;

    localparam logic [IW-1:0]            I_LAST  = IW'(HID_DIM - 1);
    localparam logic [7:0]               O_LAST  = 8'(CHAR_NUM - 1);
    localparam logic signed [ACCW-1:0]   SAT_MAX = ACCW'((64'sd1 <<< (DWIDTH-1)) - 64'sd1);
    localparam logic signed [ACCW-1:0]   SAT_MIN = -SAT_MAX - ACCW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                          state_q, state_d;
    logic [HID_DIM-1:0][DWIDTH-1:0]  x_q, x_d;
    logic [IW-1:0]                   i_q, i_d;
    logic [IW-1:0]                   idx_q, idx_d;     // element index of the returning rom_q
    logic                            vld_q, vld_d;     // rom_q carries a weight this cycle
    logic [AWIDTH-1:0]               base_q, base_d;
    logic [AWIDTH-1:0]               rom_addr_q, rom_addr_d;
    logic signed [ACCW-1:0]          acc_q, acc_d;
    logic [7:0]                      o_q, o_d;
    logic                            out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]               out_data_q, out_data_d;
    logic                            done_q, done_d;

    logic signed [DWIDTH-1:0]        x_sel;
    logic signed [DWIDTH-1:0]        w_sel;
    logic signed [2*DWIDTH-1:0]      prod;
    logic signed [ACCW-1:0]          acc_sum;
    logic signed [ACCW-1:0]          shifted;
    logic [DWIDTH-1:0]               sat_val;

    // Datapath: product of the delayed element and the returning weight.
    always_comb begin
        x_sel   = x_q[idx_q];
        w_sel   = rom_q;
        prod    = x_sel * w_sel;
        acc_sum = vld_q ? (acc_q + ACCW'(prod)) : acc_q;
        // Arithmetic shift floors toward minus infinity.
        shifted = acc_sum >>> FRAC;
        if (shifted > SAT_MAX)
            sat_val = SAT_MAX[DWIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat_val = SAT_MIN[DWIDTH-1:0];
        else
            sat_val = shifted[DWIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        i_d         = i_q;
        idx_d       = idx_q;
        vld_d       = 1'b0;
        base_d      = base_q;
        rom_addr_d  = rom_addr_q;
        acc_d       = acc_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = x_in;
                    i_d        = '0;
                    o_d        = '0;
                    acc_d      = '0;
                    base_d     = '0;
                    rom_addr_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                vld_d = 1'b1;
                idx_d = i_q;
                if (i_q == I_LAST) begin
                    // Address holds on the last element so it never runs
                    // past the end of the ROM.
                    state_d = S_DRAIN;
                end else begin
                    i_d        = i_q + IW'(1);
                    rom_addr_d = rom_addr_q + AWIDTH'(1);
                end
            end
            S_DRAIN: begin
                acc_d       = acc_sum;
                out_data_d  = sat_val;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (o_q == O_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        o_d        = o_q + 8'd1;
                        base_d     = base_q + AWIDTH'(HID_DIM);
                        rom_addr_d = base_q + AWIDTH'(HID_DIM);
                        i_d        = '0;
                        acc_d      = '0;
                        state_d    = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            i_q         <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            base_q      <= '0;
            rom_addr_q  <= '0;
            acc_q       <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            i_q         <= i_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
            base_q      <= base_d;
            rom_addr_q  <= rom_addr_d;
            acc_q       <= acc_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = o_q;
    assign done      = done_q;

endmodule
